// File: rtl/decoy_odelay_ctrl.sv
// ODELAY3 tap controller: moves a delay line to a requested tap one CE pulse
// at a time, with VTC tracking suspended around the move and an optional
// PPS-aligned start. Readback is verified when the move completes.
module decoy_odelay_ctrl #(
  parameter int TAP_WIDTH  = 9,
  parameter int MAX_TAP    = 511,
  parameter int VTC_SETTLE = 10,
  parameter int STEP_GAP   = 4
) (
  input  logic                 s_axil_aclk,
  input  logic                 s_axil_aresetn,
  input  logic                 pps_i,
  input  logic [TAP_WIDTH-1:0] cfg_tap_target,
  input  logic                 cfg_sync_pps,
  input  logic                 cfg_tap_valid,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 err_busy,
  output logic                 err_mismatch,
  input  logic [TAP_WIDTH-1:0] odelay_cntvalueout,
  output logic                 odelay_ce,
  output logic                 odelay_inc,
  output logic                 odelay_en_vtc
);

  localparam int CNT_MAX = (VTC_SETTLE > STEP_GAP) ? VTC_SETTLE : STEP_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(VTC_SETTLE - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST    = CNT_W'(STEP_GAP - 1);
  localparam logic [TAP_WIDTH-1:0] MAX_T       = TAP_WIDTH'(MAX_TAP);

  typedef enum logic [2:0] {
    IDLE, WAIT_PPS, VTC_OFF, STEP, GAP, VTC_ON, DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [TAP_WIDTH-1:0] target;
  logic [TAP_WIDTH-1:0] cur_tap;

  logic                 req_vld;
  logic                 req_sync;
  logic [TAP_WIDTH-1:0] req_tap;

  logic pps_meta, pps_sync, pps_prev;
  logic pps_rise;

  // Saturate a requested tap to the highest legal tap so cur_tap cannot wrap
  function automatic logic [TAP_WIDTH-1:0] clamp_tap(input logic [TAP_WIDTH-1:0] t);
    return (t > MAX_T) ? MAX_T : t;
  endfunction

  // One tap towards the target in the direction already driven on INC
  function automatic logic [TAP_WIDTH-1:0] step_tap(input logic [TAP_WIDTH-1:0] t,
                                                    input logic up);
    return up ? (t + 1'b1) : (t - 1'b1);
  endfunction

  assign pps_rise = pps_sync & ~pps_prev;

  // Request strobe/mode register stage (control only)
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      req_vld  <= 1'b0;
      req_sync <= 1'b0;
    end else begin
      req_vld  <= cfg_tap_valid;
      req_sync <= cfg_sync_pps;
    end
  end

  // Requested tap value travels with req_vld; data path needs no reset
  always_ff @(posedge s_axil_aclk) begin
    req_tap <= cfg_tap_target;
  end

  // Two-flop PPS synchroniser plus a delayed copy for rising-edge detect
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      pps_meta <= 1'b0;
      pps_sync <= 1'b0;
      pps_prev <= 1'b0;
    end else begin
      pps_meta <= pps_i;
      pps_sync <= pps_meta;
      pps_prev <= pps_sync;
    end
  end

  // Sequencer: VTC off, settle, step CE with gaps, VTC on, settle, verify
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      state         <= IDLE;
      cnt           <= '0;
      target        <= '0;
      cur_tap       <= '0;
      odelay_ce     <= 1'b0;
      odelay_inc    <= 1'b0;
      odelay_en_vtc <= 1'b1;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      err_busy      <= 1'b0;
      err_mismatch  <= 1'b0;
    end else begin
      odelay_ce <= 1'b0;
      cfg_done  <= 1'b0;
      err_busy  <= req_vld && (state != IDLE);
      case (state)
        IDLE: begin
          if (req_vld) begin
            target       <= clamp_tap(req_tap);
            err_mismatch <= 1'b0;
            cfg_busy     <= 1'b1;
            cnt          <= '0;
            if (req_sync) begin
              state <= WAIT_PPS;
            end else begin
              state         <= VTC_OFF;
              odelay_en_vtc <= 1'b0;
            end
          end
        end
        WAIT_PPS: begin
          if (pps_rise) begin
            state         <= VTC_OFF;
            odelay_en_vtc <= 1'b0;
            cnt           <= '0;
          end
        end
        VTC_OFF: begin
          if (cnt == SETTLE_LAST) begin
            cnt     <= '0;
            cur_tap <= odelay_cntvalueout;
            if (odelay_cntvalueout != target) begin
              state      <= STEP;
              odelay_ce  <= 1'b1;
              odelay_inc <= (target > odelay_cntvalueout);
            end else begin
              state         <= VTC_ON;
              odelay_en_vtc <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STEP: begin
          cur_tap <= step_tap(cur_tap, odelay_inc);
          cnt     <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (cur_tap != target) begin
              state      <= STEP;
              odelay_ce  <= 1'b1;
              odelay_inc <= (target > cur_tap);
            end else begin
              state         <= VTC_ON;
              odelay_en_vtc <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        VTC_ON: begin
          if (cnt == SETTLE_LAST) begin
            cnt      <= '0;
            state    <= DONE;
            cfg_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (odelay_cntvalueout != target) err_mismatch <= 1'b1;
          cfg_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoy_odelay_ctrl.sv
// Bench for decoy_odelay_ctrl: an ODELAY3 tap model driven by CE/INC, a
// transaction-level predictor of pulse count, timing and readback, and a
// protocol monitor for CE/EN_VTC rules.
module tb_decoy_odelay_ctrl;

  localparam int TW     = 10;
  localparam int MAXT   = 511;
  localparam int SETTLE = 10;
  localparam int SGAP   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pps_i = 1'b0;
  logic [TW-1:0] cfg_tap_target = '0;
  logic          cfg_sync_pps = 1'b0;
  logic          cfg_tap_valid = 1'b0;
  logic          cfg_busy, cfg_done, err_busy, err_mismatch;
  logic [TW-1:0] cntvalueout;
  logic          odelay_ce, odelay_inc, odelay_en_vtc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // written only by the monitor
  int   step_sum = 0, ce_total = 0, done_total = 0, errb_total = 0, viol = 0, ign_done = 0;
  int   fall_cyc = 0, rise_cyc = 0, done_cyc = 0, last_ce_cyc = -100;
  logic err_at_fall = 1'b0, prev_ce = 1'b0, prev_en = 1'b1;

  // written only by the stimulus process
  int   tap_base = 0, ign_req = 0;
  logic exp_inc = 1'b0;

  assign cntvalueout = TW'(tap_base + step_sum);

  decoy_odelay_ctrl #(
    .TAP_WIDTH(TW), .MAX_TAP(MAXT), .VTC_SETTLE(SETTLE), .STEP_GAP(SGAP)
  ) dut (
    .s_axil_aclk       (clk),
    .s_axil_aresetn    (rst_n),
    .pps_i             (pps_i),
    .cfg_tap_target    (cfg_tap_target),
    .cfg_sync_pps      (cfg_sync_pps),
    .cfg_tap_valid     (cfg_tap_valid),
    .cfg_busy          (cfg_busy),
    .cfg_done          (cfg_done),
    .err_busy          (err_busy),
    .err_mismatch      (err_mismatch),
    .odelay_cntvalueout(cntvalueout),
    .odelay_ce         (odelay_ce),
    .odelay_inc        (odelay_inc),
    .odelay_en_vtc     (odelay_en_vtc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Delay-line model and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (odelay_ce === 1'b1) begin
      ce_total++;
      if (odelay_en_vtc !== 1'b0) viol++;
      if (prev_ce) viol++;
      if (odelay_inc !== exp_inc) viol++;
      if (last_ce_cyc > fall_cyc) begin
        if (cyc - last_ce_cyc != SGAP + 1) viol++;
      end else if (cyc - fall_cyc != SETTLE) begin
        viol++;
      end
      last_ce_cyc = cyc;
      if (ign_done < ign_req) ign_done++;
      else step_sum += odelay_inc ? 1 : -1;
    end
    if (prev_en && odelay_en_vtc === 1'b0) begin
      fall_cyc    = cyc;
      err_at_fall = err_mismatch;
    end
    if (!prev_en && odelay_en_vtc === 1'b1) rise_cyc = cyc;
    if (cfg_done === 1'b1) begin
      done_total++;
      done_cyc = cyc;
    end
    if (err_busy === 1'b1) errb_total++;
    prev_ce = (odelay_ce === 1'b1);
    prev_en = (odelay_en_vtc !== 1'b0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One request from strobe to completion, predicted from the start tap
  task automatic run_req(input int req, input bit sync, input int start, input int pps_dly,
                         input bit second, input bit ign);
    int   tgt, n, fin, s_ce, s_done, s_errb, s_viol, strobe_cyc, pps_cyc, wait_bad;
    bit   sent, seen;
    logic up;
    tgt = (req > MAXT) ? MAXT : req;
    n   = (tgt > start) ? tgt - start : start - tgt;
    up  = (tgt > start);
    fin = tgt;
    if (ign && n > 0) fin = up ? tgt - 1 : tgt + 1;
    tick();
    tap_base = start - step_sum;
    exp_inc  = up;
    if (ign && n > 0) ign_req++;
    s_ce = ce_total; s_done = done_total; s_errb = errb_total; s_viol = viol;
    cfg_tap_target = TW'(req);
    cfg_sync_pps   = sync;
    cfg_tap_valid  = 1'b1;
    strobe_cyc     = cyc;
    tick();
    cfg_tap_valid = 1'b0;
    wait_bad = 0;
    pps_cyc  = 0;
    if (sync) begin
      for (int i = 0; i < pps_dly; i++) begin
        tick();
        if (cfg_busy !== 1'b1 || odelay_en_vtc !== 1'b1) wait_bad++;
      end
      pps_cyc = cyc;
      pps_i   = 1'b1;
    end
    seen = 0;
    sent = 0;
    for (int k = 0; k < 400 + 6 * n && !seen; k++) begin
      tick();
      if (cfg_tap_valid) cfg_tap_valid = 1'b0;
      if (second && !sent && odelay_ce === 1'b1) begin
        cfg_tap_target = TW'((tgt + 37) % 512);
        cfg_sync_pps   = 1'b0;
        cfg_tap_valid  = 1'b1;
        sent = 1;
      end
      if (done_total != s_done) seen = 1;
    end
    cfg_tap_valid = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    if (sync) begin
      check_eq("wait_pps_hold", wait_bad, 0);
      check_eq("pps_to_vtc_off", fall_cyc - pps_cyc, 3);
    end else begin
      check_eq("strobe_to_vtc_off", fall_cyc - strobe_cyc, 2);
    end
    check_eq("done_latency", done_cyc - fall_cyc, 2 * SETTLE + (SGAP + 1) * n);
    check_eq("ce_pulses", ce_total - s_ce, n);
    check_eq("vtc_on_hold", done_cyc - rise_cyc, SETTLE);
    check_eq("protocol", viol - s_viol, 0);
    check_eq("err_clear_on_accept", 32'(err_at_fall), 32'd0);
    check_eq("err_busy_pulses", errb_total - s_errb, 32'(second && n > 0));
    tick();
    check_eq("done_width", done_total - s_done, 1);
    check_eq("busy_after", 32'(cfg_busy), 32'd0);
    check_eq("err_mismatch", 32'(err_mismatch), 32'(fin != tgt));
    check_eq("readback", tap_base + step_sum, fin);
    pps_i = 1'b0;
  endtask

  // Abort a move with reset while the controller sits in a CE gap
  task automatic reset_in_gap();
    int s_ce;
    bit seen;
    tick();
    tap_base = 100 - step_sum;
    exp_inc  = 1'b1;
    cfg_tap_target = TW'(110);
    cfg_sync_pps   = 1'b0;
    cfg_tap_valid  = 1'b1;
    tick();
    cfg_tap_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      if (odelay_ce === 1'b1) seen = 1;
    end
    check_eq("rst_ce_seen", 32'(seen), 32'd1);
    tick();
    check_eq("rst_in_gap_vtc", 32'(odelay_en_vtc), 32'd0);
    s_ce = ce_total;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ce", 32'(odelay_ce), 32'd0);
    check_eq("rst_en_vtc", 32'(odelay_en_vtc), 32'd1);
    check_eq("rst_busy", 32'(cfg_busy), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_eq("rst_no_more_ce", ce_total - s_ce, 0);
    check_eq("rst_idle_busy", 32'(cfg_busy), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("reset_ce", 32'(odelay_ce), 32'd0);
    check_eq("reset_inc", 32'(odelay_inc), 32'd0);
    check_eq("reset_en_vtc", 32'(odelay_en_vtc), 32'd1);
    check_eq("reset_busy", 32'(cfg_busy), 32'd0);
    check_eq("reset_done", 32'(cfg_done), 32'd0);
    check_eq("reset_err_busy", 32'(err_busy), 32'd0);
    check_eq("reset_err_mismatch", 32'(err_mismatch), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_req(55, 0, 50, 0, 0, 0);
    run_req(47, 0, 50, 0, 0, 0);
    run_req(50, 0, 50, 0, 0, 0);
    run_req(600, 0, 505, 0, 0, 0);
    run_req(58, 1, 52, 1000, 0, 0);
    run_req(60, 0, 50, 0, 1, 0);
    run_req(45, 0, 50, 0, 0, 1);
    repeat (5) tick();
    check_eq("err_sticky", 32'(err_mismatch), 32'd1);
    run_req(48, 0, 46, 0, 0, 0);
    reset_in_gap();

    for (int r = 0; r < 12; r++) begin
      int st, rq, d;
      bit sy, sc, ig;
      if ($urandom_range(0, 3) == 0) begin
        st = $urandom_range(500, 511);
        rq = $urandom_range(512, 1023);
      end else begin
        st = $urandom_range(0, 511);
        d  = $urandom_range(0, 16);
        rq = st + d - 8;
        if (rq < 0) rq = 0;
      end
      sy = ($urandom_range(0, 3) == 0);
      sc = ($urandom_range(0, 3) == 0);
      ig = ($urandom_range(0, 4) == 0);
      run_req(rq, sy, st, $urandom_range(20, 60), sc, ig);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
